// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// mips_pkg
// Shared encodings for the MIPS pipeline hazard unit (forward selects, Tnew/Tuse).
// Revision: 1.0
// ============================================================================
package mips_pkg;

  typedef logic [1:0] tnew_t;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  localparam tnew_t TUSE_NONE = 2'd3;
  localparam tnew_t TNEW_ALU  = 2'd1;
  localparam tnew_t TNEW_LW   = 2'd2;

  // EX operand select: only MEM (when its result is ready) or WB can supply it.
  function automatic logic [1:0] fwd_ex_sel(
    input logic [4:0] src,
    input logic [4:0] mem_rd,
    input tnew_t      mem_tnew,
    input logic [4:0] wb_rd
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (src != 5'd0) begin
      if (src == mem_rd)
        sel = (mem_tnew == 2'd0) ? FWD_EXMEM : FWD_RF;
      else if (src == wb_rd)
        sel = FWD_MEMWB;
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_src_check.sv
`default_nettype none
// ============================================================================
// hazard_src_check
// Stall and ID-forward decision for one source operand against EX/MEM/WB.
// Revision: 1.0
// ============================================================================
module hazard_src_check
  import mips_pkg::*;
#(
  parameter tnew_t TUSE_NONE = 2'd3
) (
  input  logic [4:0] i_src,
  input  tnew_t      i_tuse,
  input  logic [4:0] i_ex_rd,
  input  tnew_t      i_ex_tnew,
  input  logic [4:0] i_mem_rd,
  input  tnew_t      i_mem_tnew,
  input  logic [4:0] i_wb_rd,
  output logic       o_stall,
  output logic [1:0] o_fwd_id
);

  logic w_used;
  logic w_ex_hit;
  logic w_mem_hit;
  logic w_wb_hit;

  assign w_used    = (i_src != 5'd0) && (i_tuse != TUSE_NONE);
  assign w_ex_hit  = (i_src != 5'd0) && (i_src == i_ex_rd);
  assign w_mem_hit = (i_src != 5'd0) && (i_src == i_mem_rd);
  assign w_wb_hit  = (i_src != 5'd0) && (i_src == i_wb_rd);

  // Nearest matching stage wins; older stages are shadowed by a newer match.
  always_comb begin
    o_stall  = 1'b0;
    o_fwd_id = FWD_RF;
    if (w_ex_hit) begin
      o_stall = w_used && (i_ex_tnew > i_tuse);
    end else if (w_mem_hit) begin
      o_stall  = w_used && (i_mem_tnew > i_tuse);
      o_fwd_id = (i_mem_tnew == 2'd0) ? FWD_EXMEM : FWD_RF;
    end else if (w_wb_hit) begin
      o_fwd_id = FWD_MEMWB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_tnew_tracker.sv
`default_nettype none
// ============================================================================
// hazard_tnew_tracker
// Tracks producer rd/Tnew through EX/MEM/WB, raises stalls and forward selects.
// Revision: 1.0
// ============================================================================
module hazard_tnew_tracker
  import mips_pkg::*;
#(
  parameter int    CNT_W     = 16,
  parameter tnew_t TUSE_NONE = 2'd3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rd_ID,
  input  tnew_t            tnew_ID,
  input  logic [4:0]       rs_ID,
  input  logic [4:0]       rt_ID,
  input  tnew_t            tuse_rs_ID,
  input  tnew_t            tuse_rt_ID,
  output logic             stop,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_clr,
  output logic [1:0]       fwd_rs_ID,
  output logic [1:0]       fwd_rt_ID,
  output logic [1:0]       fwd_rs_EX,
  output logic [1:0]       fwd_rt_EX,
  output logic [4:0]       rd_EX,
  output tnew_t            tnew_EX,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [4:0]       r_ex_rd;
  tnew_t            r_ex_tnew;
  logic [4:0]       r_ex_rs;
  logic [4:0]       r_ex_rt;
  logic [4:0]       r_mem_rd;
  tnew_t            r_mem_tnew;
  logic [4:0]       r_wb_rd;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_stall_rs;
  logic w_stall_rt;

  hazard_src_check #(.TUSE_NONE(TUSE_NONE)) u_chk_rs (
    .i_src      (rs_ID),
    .i_tuse     (tuse_rs_ID),
    .i_ex_rd    (r_ex_rd),
    .i_ex_tnew  (r_ex_tnew),
    .i_mem_rd   (r_mem_rd),
    .i_mem_tnew (r_mem_tnew),
    .i_wb_rd    (r_wb_rd),
    .o_stall    (w_stall_rs),
    .o_fwd_id   (fwd_rs_ID)
  );

  hazard_src_check #(.TUSE_NONE(TUSE_NONE)) u_chk_rt (
    .i_src      (rt_ID),
    .i_tuse     (tuse_rt_ID),
    .i_ex_rd    (r_ex_rd),
    .i_ex_tnew  (r_ex_tnew),
    .i_mem_rd   (r_mem_rd),
    .i_mem_tnew (r_mem_tnew),
    .i_wb_rd    (r_wb_rd),
    .o_stall    (w_stall_rt),
    .o_fwd_id   (fwd_rt_ID)
  );

  assign stop      = w_stall_rs | w_stall_rt;
  assign pc_en     = ~stop;
  assign ifid_en   = ~stop;
  assign idex_clr  = stop;
  assign fwd_rs_EX = fwd_ex_sel(r_ex_rs, r_mem_rd, r_mem_tnew, r_wb_rd);
  assign fwd_rt_EX = fwd_ex_sel(r_ex_rt, r_mem_rd, r_mem_tnew, r_wb_rd);
  assign rd_EX     = r_ex_rd;
  assign tnew_EX   = r_ex_tnew;
  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_rd     <= 5'd0;
      r_ex_tnew   <= 2'd0;
      r_ex_rs     <= 5'd0;
      r_ex_rt     <= 5'd0;
      r_mem_rd    <= 5'd0;
      r_mem_tnew  <= 2'd0;
      r_wb_rd     <= 5'd0;
      r_stall_cnt <= {CNT_W{1'b0}};
    end else begin
      // A stall injects a bubble into EX while older stages keep draining.
      if (stop) begin
        r_ex_rd   <= 5'd0;
        r_ex_tnew <= 2'd0;
        r_ex_rs   <= 5'd0;
        r_ex_rt   <= 5'd0;
      end else begin
        r_ex_rd   <= rd_ID;
        r_ex_tnew <= tnew_ID;
        r_ex_rs   <= rs_ID;
        r_ex_rt   <= rt_ID;
      end
      r_mem_rd   <= r_ex_rd;
      r_mem_tnew <= (r_ex_tnew == 2'd0) ? 2'd0 : r_ex_tnew - 2'd1;
      r_wb_rd    <= r_mem_rd;
      if (stop && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_tnew_tracker.sv
`default_nettype none
// ============================================================================
// tb_hazard_tnew_tracker
// Directed + random bench against an age-based in-flight instruction model.
// Revision: 1.0
// ============================================================================
module tb_hazard_tnew_tracker;

  logic       clk;
  logic       rst_n;
  logic [4:0] rd_ID, rs_ID, rt_ID;
  logic [1:0] tnew_ID, tuse_rs_ID, tuse_rt_ID;
  logic       stop, pc_en, ifid_en, idex_clr;
  logic [1:0] fwd_rs_ID, fwd_rt_ID, fwd_rs_EX, fwd_rt_EX;
  logic [4:0] rd_EX;
  logic [1:0] tnew_EX;
  logic [15:0] stall_cnt;

  logic       stop2, pc_en2, ifid_en2, idex_clr2;
  logic [1:0] frs_id2, frt_id2, frs_ex2, frt_ex2;
  logic [4:0] rd_ex2;
  logic [1:0] tnew_ex2;
  logic [1:0] stall_cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_tnew_tracker #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .rd_ID(rd_ID), .tnew_ID(tnew_ID),
    .rs_ID(rs_ID), .rt_ID(rt_ID), .tuse_rs_ID(tuse_rs_ID), .tuse_rt_ID(tuse_rt_ID),
    .stop(stop), .pc_en(pc_en), .ifid_en(ifid_en), .idex_clr(idex_clr),
    .fwd_rs_ID(fwd_rs_ID), .fwd_rt_ID(fwd_rt_ID), .fwd_rs_EX(fwd_rs_EX),
    .fwd_rt_EX(fwd_rt_EX), .rd_EX(rd_EX), .tnew_EX(tnew_EX), .stall_cnt(stall_cnt)
  );

  hazard_tnew_tracker #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .rd_ID(rd_ID), .tnew_ID(tnew_ID),
    .rs_ID(rs_ID), .rt_ID(rt_ID), .tuse_rs_ID(tuse_rs_ID), .tuse_rt_ID(tuse_rt_ID),
    .stop(stop2), .pc_en(pc_en2), .ifid_en(ifid_en2), .idex_clr(idex_clr2),
    .fwd_rs_ID(frs_id2), .fwd_rt_ID(frt_id2), .fwd_rs_EX(frs_ex2),
    .fwd_rt_EX(frt_ex2), .rd_EX(rd_ex2), .tnew_EX(tnew_ex2), .stall_cnt(stall_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  // Model: slot 0=EX, 1=MEM, 2=WB; each holds the producer's original Tnew and
  // the remaining Tnew is derived from the slot's age.
  int m_rd[3];
  int m_tn[3];
  int m_ex_rs, m_ex_rt;
  int m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic int rem(input int k);
    int r;
    if (k >= 2) return 0;
    r = m_tn[k] - k;
    return (r > 0) ? r : 0;
  endfunction

  function automatic int m_stall(input int s, input int t);
    if (s == 0 || t == 3) return 0;
    for (int k = 0; k < 3; k++)
      if (m_rd[k] == s) return (rem(k) > t) ? 1 : 0;
    return 0;
  endfunction

  function automatic int m_fwd(input int s, input bit id_side);
    if (s == 0) return 0;
    if (id_side && m_rd[0] == s) return 0;
    if (m_rd[1] == s) return (rem(1) == 0) ? 1 : 0;
    if (m_rd[2] == s) return 2;
    return 0;
  endfunction

  function automatic int sat3(input int c);
    return (c > 3) ? 3 : c;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_rd[k] = 0;
      m_tn[k] = 0;
    end
    m_ex_rs = 0;
    m_ex_rt = 0;
    m_cnt   = 0;
  endtask

  task automatic check_all(output int exp_stop);
    exp_stop = m_stall(rs_ID, tuse_rs_ID) | m_stall(rt_ID, tuse_rt_ID);
    chk("stop", stop, exp_stop);
    chk("pc_en", pc_en, !exp_stop);
    chk("ifid_en", ifid_en, !exp_stop);
    chk("idex_clr", idex_clr, exp_stop);
    chk("fwd_rs_ID", fwd_rs_ID, m_fwd(rs_ID, 1));
    chk("fwd_rt_ID", fwd_rt_ID, m_fwd(rt_ID, 1));
    chk("fwd_rs_EX", fwd_rs_EX, m_fwd(m_ex_rs, 0));
    chk("fwd_rt_EX", fwd_rt_EX, m_fwd(m_ex_rt, 0));
    chk("rd_EX", rd_EX, m_rd[0]);
    chk("tnew_EX", tnew_EX, m_tn[0]);
    chk("stall_cnt", stall_cnt, m_cnt);
    chk("stall_cnt_sat", stall_cnt2, sat3(m_cnt));
  endtask

  // Drives one ID instruction for one cycle (called at negedge), checks, advances.
  task automatic step(input int rd, input int tn, input int rs, input int trs,
                      input int rt, input int trt, output int stalled);
    int s;
    rd_ID = rd[4:0]; tnew_ID = tn[1:0];
    rs_ID = rs[4:0]; tuse_rs_ID = trs[1:0];
    rt_ID = rt[4:0]; tuse_rt_ID = trt[1:0];
    #1;
    check_all(s);
    @(posedge clk);
    m_cnt += s;
    m_rd[2] = m_rd[1]; m_tn[2] = m_tn[1];
    m_rd[1] = m_rd[0]; m_tn[1] = m_tn[0];
    if (s != 0) begin
      m_rd[0] = 0; m_tn[0] = 0; m_ex_rs = 0; m_ex_rt = 0;
    end else begin
      m_rd[0] = rd; m_tn[0] = tn; m_ex_rs = rs; m_ex_rt = rt;
    end
    @(negedge clk);
    stalled = s;
  endtask

  // Holds an instruction in ID until it is accepted; returns stall cycles seen.
  task automatic issue(input int rd, input int tn, input int rs, input int trs,
                       input int rt, input int trt, output int nstall);
    int st;
    nstall = 0;
    for (int i = 0; i < 6; i++) begin
      step(rd, tn, rs, trs, rt, trt, st);
      if (st == 0) return;
      nstall++;
    end
    chk("issue_bound", 1, 0);
  endtask

  task automatic nops(input int n);
    int d;
    for (int i = 0; i < n; i++) issue(0, 0, 0, 3, 0, 3, d);
  endtask

  initial begin
    int ns, d, base;
    rst_n = 1'b0;
    rd_ID = '0; tnew_ID = '0; rs_ID = '0; rt_ID = '0;
    tuse_rs_ID = 2'd3; tuse_rt_ID = 2'd3;
    model_reset();
    @(negedge clk);
    #1;
    check_all(d);
    @(negedge clk);
    rst_n = 1'b1;

    // lw r1 ; add rs=r1
    issue(1, 2, 0, 3, 0, 3, d);
    base = m_cnt;
    issue(0, 1, 1, 1, 0, 3, ns);
    chk("c1_stalls", ns, 1);
    chk("c1_cnt", stall_cnt, base + 1);
    issue(0, 0, 0, 3, 0, 3, d);   // add in EX: checked against WB forward
    nops(3);

    // add r2 ; beq rs=r2
    issue(2, 1, 0, 3, 0, 3, d);
    issue(0, 0, 2, 0, 0, 3, ns);
    chk("c2_stalls", ns, 1);
    nops(3);

    // lw r3 ; beq rt=r3
    issue(3, 2, 0, 3, 0, 3, d);
    issue(0, 0, 0, 3, 3, 0, ns);
    chk("c3_stalls", ns, 2);
    nops(3);

    // $0 producer / consumer
    issue(0, 2, 0, 3, 0, 3, d);
    issue(0, 1, 0, 0, 0, 0, ns);
    chk("c4_stalls", ns, 0);
    nops(3);

    // add r4 ; add r4 ; add rs=r4 -> newest producer forwards
    issue(4, 1, 0, 3, 0, 3, d);
    issue(4, 1, 0, 3, 0, 3, d);
    issue(0, 1, 4, 1, 0, 3, ns);
    chk("c5_stalls", ns, 0);
    issue(0, 0, 0, 3, 0, 3, d);
    nops(3);

    // Reset asserted during the first stall cycle of lw ; beq
    issue(3, 2, 0, 3, 0, 3, d);
    rd_ID = 5'd0; tnew_ID = 2'd0; rs_ID = 5'd0; tuse_rs_ID = 2'd3;
    rt_ID = 5'd3; tuse_rt_ID = 2'd0;
    #1;
    chk("c6_pre_stop", stop, 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("c6_rst_stop", stop, 0);
    chk("c6_rst_pc_en", pc_en, 1);
    chk("c6_rst_cnt", stall_cnt, 0);
    chk("c6_rst_rd_EX", rd_EX, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Five stall cycles: narrow counter saturates at 3
    issue(3, 2, 0, 3, 0, 3, d);
    issue(0, 0, 0, 3, 3, 0, d);
    issue(5, 2, 0, 3, 0, 3, d);
    issue(0, 0, 5, 0, 0, 3, d);
    issue(6, 2, 0, 3, 0, 3, d);
    issue(0, 1, 6, 1, 0, 3, d);
    chk("c6_cnt5", stall_cnt, 5);
    chk("c6_sat", stall_cnt2, 3);
    nops(2);

    // Random legal instruction stream over a small register set
    for (int i = 0; i < 400; i++) begin
      issue($urandom_range(0, 4), $urandom_range(0, 2),
            $urandom_range(0, 4), $urandom_range(0, 3),
            $urandom_range(0, 4), $urandom_range(0, 3), d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
